// File: rtl/motion_indicator.sv
// Car lamp and odometer front end: turns level turn/move requests into blinking
// indicator lamps, a reverse lamp and a 4-digit BCD odometer with a tick pulse.
module motion_indicator #(
   parameter int BLINK_DIV = 50_000_000,
   parameter int MILE_DIV  = 100_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        power,
   input  logic        turn_left,
   input  logic        turn_right,
   input  logic        move_forward,
   input  logic        move_backward,
   input  logic        odo_clear,
   output logic        left_lamp,
   output logic        right_lamp,
   output logic        reverse_lamp,
   output logic [15:0] odo_bcd,
   output logic        odo_tick
);

   localparam int BW = $clog2(BLINK_DIV);
   localparam int DW = $clog2(MILE_DIV);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [DW-1:0] DIST_LAST  = DW'(MILE_DIV - 1);

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_LEFT   = 2'd1,
      MODE_RIGHT  = 2'd2,
      MODE_HAZARD = 2'd3
   } mode_t;

   mode_t          r_mode;
   mode_t          w_mode_nxt;
   logic [BW-1:0]  r_blink_cnt;
   logic           r_phase;
   logic           r_reverse;
   logic [DW-1:0]  r_dist;
   logic [15:0]    r_bcd;
   logic           r_tick;
   logic           w_moving;

   // Decimal increment with ripple carry; 9999 rolls over to 0000.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] res;
      logic        carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (res[i*4 +: 4] == 4'd9) begin
               res[i*4 +: 4] = 4'd0;
            end else begin
               res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_mode <= MODE_OFF;
      else        r_mode <= w_mode_nxt;
   end

   always_comb begin
      w_mode_nxt = MODE_OFF;
      if (power) begin
         case ({turn_left, turn_right})
            2'b10:   w_mode_nxt = MODE_LEFT;
            2'b01:   w_mode_nxt = MODE_RIGHT;
            2'b11:   w_mode_nxt = MODE_HAZARD;
            default: w_mode_nxt = MODE_OFF;
         endcase
      end
   end

   // Any mode change restarts the blink so the new lamps come on lit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (w_mode_nxt != r_mode) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (r_mode != MODE_OFF) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
         end
      end
   end

   assign left_lamp  = r_phase & ((r_mode == MODE_LEFT)  | (r_mode == MODE_HAZARD));
   assign right_lamp = r_phase & ((r_mode == MODE_RIGHT) | (r_mode == MODE_HAZARD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_reverse <= 1'b0;
      else        r_reverse <= power & move_backward & ~move_forward;
   end

   assign reverse_lamp = r_reverse;

   // Both directions at once is treated as invalid and does not count.
   assign w_moving = power & (move_forward ^ move_backward);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dist <= '0;
         r_bcd  <= 16'h0000;
         r_tick <= 1'b0;
      end else if (odo_clear) begin
         r_dist <= '0;
         r_bcd  <= 16'h0000;
         r_tick <= 1'b0;
      end else if (w_moving) begin
         if (r_dist == DIST_LAST) begin
            r_dist <= '0;
            r_bcd  <= bcd_inc(r_bcd);
            r_tick <= 1'b1;
         end else begin
            r_dist <= r_dist + DW'(1);
            r_tick <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign odo_bcd  = r_bcd;
   assign odo_tick = r_tick;

endmodule

// File: doc/motion_indicator.md
# motion_indicator

Downstream consumer of the manual-driving controller's turn and move signals. It turns them into the car's visible outputs: blinking turn and hazard lamps, a reverse lamp, and a 4-digit BCD odometer. The odometer advances while the car moves in either direction. All outputs feed the board LEDs and the seven-segment display driver.

## Interface
Parameters:
- BLINK_DIV, default 50_000_000: lamp half-period in clk cycles; must be ≥ 2.
- MILE_DIV, default 100_000_000: moving clk cycles per odometer unit; must be ≥ 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- power  input  1  car powered; 0 forces lamps off and freezes the odometer.
- turn_left  input  1  left-turn request, level.
- turn_right  input  1  right-turn request, level.
- move_forward  input  1  car moving forward, level.
- move_backward  input  1  car moving backward, level.
- odo_clear  input  1  synchronous odometer clear, single-cycle or level.
- left_lamp  output  1  left indicator.
- right_lamp  output  1  right indicator.
- reverse_lamp  output  1  reverse light.
- odo_bcd  output  16  odometer: 4 BCD digits, [15:12] most significant.
- odo_tick  output  1  one-cycle pulse on each odometer increment.

## Operation
- **Lamp mode register:** states OFF, LEFT, RIGHT, HAZARD. The next mode is computed every cycle:
  - power=0 → OFF.
  - Otherwise {turn_left, turn_right}: 00 → OFF, 10 → LEFT, 01 → RIGHT, 11 → HAZARD.
- **Blink engine:**
  - Registers: counter blink_cnt, width clog2(BLINK_DIV), and a phase bit.
  - When the next mode differs from the current mode: blink_cnt←0, phase←1. The new mode always starts with the lamp lit.
  - Otherwise, if mode ≠ OFF: blink_cnt increments; at BLINK_DIV−1 it wraps to 0 and phase toggles.
  - In OFF, blink_cnt and phase hold; their values are irrelevant.
- **Lamp decode (combinational from registers):**
  - left_lamp = phase & (mode==LEFT | mode==HAZARD).
  - right_lamp = phase & (mode==RIGHT | mode==HAZARD).
- **Reverse lamp:** reverse_lamp is a register ← power & move_backward & ~move_forward.
- **Odometer:**
  - moving = power & (move_forward XOR move_backward). Both high counts as invalid and does not count.
  - dist_cnt has width clog2(MILE_DIV). It increments while moving and holds otherwise; a partial distance is kept across stops.
  - At dist_cnt==MILE_DIV−1 while moving: dist_cnt←0, odo_bcd increments in BCD, odo_tick=1 for that one cycle (registered).
  - BCD carry: a digit at 9 goes to 0 and carries into the next digit. 9999 wraps to 0000 with odo_tick asserted; there is no overflow flag.
  - odo_clear=1: dist_cnt←0, odo_bcd←0000, odo_tick←0. odo_clear has priority over an increment in the same cycle.
  - power=0 freezes dist_cnt and odo_bcd; they are not cleared.

## Timing
- **Reset values:** mode=OFF, phase=0, blink_cnt=0, dist_cnt=0, left_lamp=0, right_lamp=0, reverse_lamp=0, odo_bcd=0000, odo_tick=0.
- **Input to lamp latency:** a turn input sampled at edge k shows its lamp high after edge k (1 cycle). The lamp then stays high BLINK_DIV cycles, low BLINK_DIV cycles, repeating.
- **Mode change mid-blink:** any mode change (for example LEFT→HAZARD) restarts the phase. The newly selected lamps are high after the same edge, for a full BLINK_DIV cycles.
- **Power drop:** power falling at edge k makes all lamps and reverse_lamp 0 after edge k. The odometer holds its value from edge k onward.
- **Odometer latency:** with moving continuously high from edge 1, the first odo_tick is high after edge MILE_DIV. Later ticks follow every MILE_DIV cycles, and odo_bcd updates in the same cycle as odo_tick.
- **Reset mid-operation:** asserting rst_n low clears everything to reset values immediately, with no dependence on clk.

## Test plan
Run with BLINK_DIV=4 and MILE_DIV=5 unless stated.
- Reset, with all inputs 0 for 10 cycles → all outputs 0, odo_bcd=0x0000, odo_tick never high.
- turn_left held 20 cycles → left_lamp 1 for cycles 1–4, 0 for 5–8, 1 for 9–12; right_lamp stays 0.
- turn_left at cycle 0, turn_right added at cycle 6 (lamp off phase) → both lamps 1 for cycles 7–10 and 0 for 11–14. Then power low at cycle 12 → both lamps 0 from cycle 13.
- move_forward for 12 cycles, 3 idle cycles, then 13 more → odo_bcd=0x0005 at the end, with odo_tick pulses after moving cycles 5, 10, 15, 20 and 25.
- move_backward → reverse_lamp 1 one cycle later. move_forward and move_backward both high for 10 cycles → reverse_lamp 0 and no counting.
- MILE_DIV=2: move for 19998 cycles → odo_bcd=0x9999; 2 more cycles → 0x0000 with odo_tick. Then odo_clear coincident with a tick → odo_bcd=0x0000 and odo_tick=0.
